// File: rtl/afe_pkg.sv
// Shared constants for the emulated SAR analog front end: S/H FSM encoding,
// track-time default and dither LFSR constants.
package afe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_TRACK = 2'd1,
    ST_HOLD  = 2'd2
  } sh_state_e;

  localparam int          N_CHNL_DEF = 18;
  localparam int          T_TRK_DEF  = 4;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/afe_sar_resp_if.sv
// Bus between the DAC multiplexer / SAR controller and the emulated front end.
interface afe_sar_resp_if #(parameter int N_CHNL = 18) ();
  logic              i_shrst;
  logic [N_CHNL-1:0] i_daci_sel;
  logic [9:0]        i_dac1;
  logic              i_wr;
  logic [4:0]        i_wr_ch;
  logic [9:0]        i_wr_val;
  logic [2:0]        r_dly;
  logic              o_comp;
  logic [9:0]        o_held;
  logic              o_sel_err;
  logic              o_trk_short;

  modport master (
    output i_shrst, i_daci_sel, i_dac1, i_wr, i_wr_ch, i_wr_val, r_dly,
    input  o_comp, o_held, o_sel_err, o_trk_short
  );

  modport slave (
    input  i_shrst, i_daci_sel, i_dac1, i_wr, i_wr_ch, i_wr_val, r_dly,
    output o_comp, o_held, o_sel_err, o_trk_short
  );
endinterface

// File: rtl/afe_sar_resp_cmp_dly.sv
// Comparator settling emulation: 8-deep shift line with a live tap select.
module cmp_dly (
  input  logic       clk,
  input  logic       srst,
  input  logic       din,
  input  logic [2:0] tap,
  output logic       dout
);
  logic [7:0] line_reg;

  always_ff @(posedge clk) begin
    if (srst) line_reg <= '0;
    else      line_reg <= {line_reg[6:0], din};
  end

  // Tap changes never flush the line; they just pick a different stage.
  assign dout = line_reg[tap];
endmodule

// File: rtl/afe_sar_resp.sv
// Emulated SAR sample/hold + comparator. Define AFE_SAR_NOISE_EN to add LFSR
// dither (-2..+1 LSB) on the held value ahead of the compare.
module afe_sar_resp
  import afe_pkg::*;
#(
  parameter int N_CHNL = N_CHNL_DEF,
  parameter int T_TRK  = T_TRK_DEF
) (
  input logic           clk,
  input logic           srst,
  afe_sar_resp_if.slave bus
);
  localparam int CNT_W = $clog2(T_TRK + 1);

  logic [9:0]        ch_val_reg [N_CHNL];
  logic [9:0]        eff_val    [N_CHNL];
  logic [N_CHNL-1:0] wr_hit;
  logic [9:0]        sel_val;
  logic              sel_any, sel_multi, sel_onehot;

  sh_state_e         state_reg, state_next;
  logic [9:0]        held_reg, held_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [N_CHNL-1:0] selq_reg, selq_next;
  logic              sel_err_reg, sel_err_next;
  logic              trk_short_reg, trk_short_next;
  logic [9:0]        cmp_val;
  logic              raw_cmp;
  logic              comp_w;

  // Per-channel write decode with same-cycle write bypass into the S/H path.
  for (genvar gi = 0; gi < N_CHNL; gi++) begin : g_ch
    assign wr_hit[gi]  = bus.i_wr && (bus.i_wr_ch == 5'(gi));
    assign eff_val[gi] = wr_hit[gi] ? bus.i_wr_val : ch_val_reg[gi];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CHNL; i++) begin
      if (srst)          ch_val_reg[i] <= '0;
      else if (wr_hit[i]) ch_val_reg[i] <= bus.i_wr_val;
    end
  end

  always_comb begin
    sel_val = '0;
    for (int i = 0; i < N_CHNL; i++)
      if (bus.i_daci_sel[i]) sel_val = sel_val | eff_val[i];
  end

  assign sel_any    = |bus.i_daci_sel;
  assign sel_multi  = |(bus.i_daci_sel & (bus.i_daci_sel - N_CHNL'(1)));
  assign sel_onehot = sel_any && !sel_multi;

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg     <= ST_EMPTY;
      held_reg      <= '0;
      cnt_reg       <= '0;
      selq_reg      <= '0;
      sel_err_reg   <= 1'b0;
      trk_short_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      held_reg      <= held_next;
      cnt_reg       <= cnt_next;
      selq_reg      <= selq_next;
      sel_err_reg   <= sel_err_next;
      trk_short_reg <= trk_short_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    held_next      = held_reg;
    cnt_next       = cnt_reg;
    selq_next      = selq_reg;
    sel_err_next   = sel_err_reg;
    trk_short_next = trk_short_reg;
    if (bus.i_shrst) begin
      state_next = ST_EMPTY;
      held_next  = '0;
      cnt_next   = '0;
    end else if (sel_multi) begin
      sel_err_next = 1'b1;
    end else if (sel_onehot) begin
      state_next = ST_TRACK;
      held_next  = sel_val;
      selq_next  = bus.i_daci_sel;
      // Fresh entry or a channel switch restarts the track timer.
      if (state_reg != ST_TRACK || bus.i_daci_sel != selq_reg)
        cnt_next = '0;
      else if (cnt_reg < CNT_W'(T_TRK))
        cnt_next = cnt_reg + CNT_W'(1);
    end else if (state_reg == ST_TRACK) begin
      state_next = ST_HOLD;
      if (cnt_reg < CNT_W'(T_TRK)) trk_short_next = 1'b1;
    end
  end

`ifdef AFE_SAR_NOISE_EN
  logic [15:0]       lfsr_reg;
  logic signed [11:0] dith_sum;

  always_ff @(posedge clk) begin
    if (srst) lfsr_reg <= LFSR_SEED;
    else      lfsr_reg <= lfsr_step(lfsr_reg);
  end

  always_comb begin
    dith_sum = $signed({2'b00, held_reg}) + $signed({{10{lfsr_reg[1]}}, lfsr_reg[1:0]});
    if (dith_sum < 12'sd0)         cmp_val = 10'h000;
    else if (dith_sum > 12'sd1023) cmp_val = 10'h3FF;
    else                           cmp_val = dith_sum[9:0];
  end
`else
  assign cmp_val = held_reg;
`endif

  assign raw_cmp = (state_reg != ST_EMPTY) && (cmp_val > bus.i_dac1);

  cmp_dly u_cmp_dly (
    .clk  (clk),
    .srst (srst),
    .din  (raw_cmp),
    .tap  (bus.r_dly),
    .dout (comp_w)
  );

  assign bus.o_comp      = comp_w;
  assign bus.o_held      = held_reg;
  assign bus.o_sel_err   = sel_err_reg;
  assign bus.o_trk_short = trk_short_reg;
endmodule

// File: tb/tb_afe_sar_resp.sv
// Directed bench for afe_sar_resp: S/H tracking, compare delay, SAR loop,
// sticky flags, S/H reset and synchronous reset.
module tb_afe_sar_resp;
  logic clk  = 1'b0;
  logic srst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  afe_sar_resp_if #(.N_CHNL(18)) bus ();

  afe_sar_resp #(.N_CHNL(18), .T_TRK(4)) dut (
    .clk  (clk),
    .srst (srst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
    end else begin
      $display("ok   %s actual=%0h", tag, act);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_ch(input logic [4:0] ch, input logic [9:0] val);
    bus.i_wr = 1'b1; bus.i_wr_ch = ch; bus.i_wr_val = val;
    tick();
    bus.i_wr = 1'b0;
  endtask

  function automatic logic [17:0] ch_bit(input int ch);
    logic [17:0] v;
    v = '0;
    v[ch] = 1'b1;
    return v;
  endfunction

  initial begin
    logic [9:0] code, trial;
    int         cnt;

    bus.i_shrst = 1'b0; bus.i_daci_sel = '0; bus.i_dac1 = 10'h3FF;
    bus.i_wr = 1'b0; bus.i_wr_ch = '0; bus.i_wr_val = '0; bus.r_dly = 3'd0;
    tick(2);
    srst = 1'b0;
    check_eq("rst_held", bus.o_held, 10'h000);
    check_eq("rst_comp", bus.o_comp, 1'b0);
    check_eq("rst_sel_err", bus.o_sel_err, 1'b0);
    check_eq("rst_trk_short", bus.o_trk_short, 1'b0);

    // ch3 = 0x200 written in the same cycle tracking starts (bypass path)
    bus.i_daci_sel = ch_bit(3);
    wr_ch(5'd3, 10'h200);
    check_eq("trk_bypass", bus.o_held, 10'h200);
    tick(5);
    bus.i_daci_sel = '0;
    tick();
    check_eq("hold_val", bus.o_held, 10'h200);
    check_eq("long_trk_ok", bus.o_trk_short, 1'b0);
    bus.r_dly = 3'd2; bus.i_dac1 = 10'h1FF;
    tick(); check_eq("dly2_t1", bus.o_comp, 1'b0);
    tick(); check_eq("dly2_t2", bus.o_comp, 1'b0);
    tick(); check_eq("dly2_t3", bus.o_comp, 1'b1);
    bus.i_dac1 = 10'h200;
    tick(2); check_eq("eq_t2", bus.o_comp, 1'b1);
    tick();  check_eq("eq_t3", bus.o_comp, 1'b0);

    // 10-bit SAR on ch0 = 0x2A4 with r_dly = 0
    bus.r_dly = 3'd0;
    wr_ch(5'd0, 10'h2A4);
    bus.i_daci_sel = ch_bit(0);
    tick(6);
    bus.i_daci_sel = '0;
    tick();
    code = '0;
    for (int b = 9; b >= 0; b--) begin
      trial = code | (10'h001 << b);
      bus.i_dac1 = trial - 10'h001;
      tick();
      if (bus.o_comp) code = trial;
    end
    check_eq("sar_code", code, 10'h2A4);

    // multi-bit select: sticky error, held value and state unchanged
    bus.i_daci_sel = 18'h00011;
    tick();
    check_eq("sel_err", bus.o_sel_err, 1'b1);
    check_eq("sel_err_held", bus.o_held, 10'h2A4);
    bus.i_daci_sel = '0;
    tick();
    check_eq("sel_err_sticky", bus.o_sel_err, 1'b1);

    // delay sweep: rising compare edge after exactly r_dly+1 cycles
    for (int d = 0; d < 8; d++) begin
      bus.r_dly = 3'(d);
      bus.i_dac1 = 10'h3FF;
      tick(10);
      bus.i_dac1 = 10'h000;
      cnt = 0;
      do begin
        tick();
        cnt++;
      end while (!bus.o_comp && cnt < 12);
      check_eq($sformatf("dly_sweep_%0d", d), cnt, d + 1);
    end

    // short track on ch5
    wr_ch(5'd5, 10'h0F0);
    bus.i_daci_sel = ch_bit(5);
    tick(2);
    bus.i_daci_sel = '0;
    tick();
    check_eq("trk_short", bus.o_trk_short, 1'b1);
    check_eq("short_held", bus.o_held, 10'h0F0);
    bus.i_daci_sel = ch_bit(5);
    tick(8);
    bus.i_daci_sel = '0;
    tick();
    check_eq("trk_short_sticky", bus.o_trk_short, 1'b1);

    // out-of-range write must not land anywhere (ch2 stays zero)
    wr_ch(5'd18, 10'h155);
    wr_ch(5'd31, 10'h2AA);
    bus.i_daci_sel = ch_bit(2);
    tick(6);
    check_eq("oob_write", bus.o_held, 10'h000);
    bus.i_daci_sel = '0;
    tick();

    // S/H reset during TRACK
    wr_ch(5'd7, 10'h3FF);
    bus.r_dly = 3'd3; bus.i_dac1 = 10'h000;
    bus.i_daci_sel = ch_bit(7);
    tick(6);
    check_eq("shrst_pre_comp", bus.o_comp, 1'b1);
    bus.i_shrst = 1'b1;
    tick();
    bus.i_shrst = 1'b0;
    bus.i_daci_sel = '0;
    check_eq("shrst_held", bus.o_held, 10'h000);
    tick(3); check_eq("shrst_comp_t3", bus.o_comp, 1'b1);
    tick();  check_eq("shrst_comp_t4", bus.o_comp, 1'b0);

    // srst in HOLD with a full compare line
    bus.r_dly = 3'd7;
    bus.i_daci_sel = ch_bit(7);
    tick(10);
    bus.i_daci_sel = '0;
    tick();
    srst = 1'b1;
    tick();
    srst = 1'b0;
    check_eq("srst_held", bus.o_held, 10'h000);
    check_eq("srst_comp", bus.o_comp, 1'b0);
    check_eq("srst_sel_err", bus.o_sel_err, 1'b0);
    check_eq("srst_trk_short", bus.o_trk_short, 1'b0);

    // channel values cleared; switching channel mid-track restarts the timer
    bus.i_daci_sel = ch_bit(7);
    tick(6);
    check_eq("srst_ch_clear", bus.o_held, 10'h000);
    bus.i_daci_sel = ch_bit(4);
    tick();
    bus.i_daci_sel = '0;
    tick();
    check_eq("switch_restart", bus.o_trk_short, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
